alu_op_sequencer: RTL and testbench

- Hardwired control unit that drives the existing CPU datapath (R0–R15, Y, Z, HI/LO, PC, MAR, MDR, IR, ALU) through instruction fetch and register-register ALU execution.
- Replaces hand-sequenced bench stimulus: it fetches the instruction, decodes IR, and steps T0..T6 one state per clock.
- Sits beside the datapath; all control outputs connect 1:1 to the datapath enable ports.

---
 rtl/alu_op_sequencer_pkg.sv | 48 ++++
 rtl/alu_op_sequencer_if.sv | 24 ++
 rtl/alu_op_sequencer_reg_sel_decode.sv | 11 +
 rtl/alu_op_sequencer.sv | 171 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Opcode map, FSM state encoding and opcode-class helpers for the
// alu_op_sequencer control unit.
package seq_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED, STEP_WAIT
  } state_t;

  // Single-bit datapath enables, registered together.
  typedef struct packed {
    logic pc_out, mar_in, inc_pc, z_in, zlo_out, zhi_out, pc_in;
    logic read, mdr_in, mdr_out, ir_in, y_in, lo_in, hi_in;
  } ctl_t;

  function automatic logic is_unary(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_binary(input logic [4:0] op);
    return (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
                       OP_SHL, OP_ROR, OP_ROL, OP_MUL, OP_DIV});
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return is_binary(op) || is_unary(op) || (op == OP_NOP) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Control bundle between the sequencer (master) and the CPU datapath (slave).
interface alu_op_sequencer_if #(parameter int OPW = 5);
  logic            start;
  logic [31:0]     IR;
  logic            PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin;
  logic            Read, MDRin, MDRout, IRin, Yin, LOin, HIin;
  logic [15:0]     Rin, Rout;
  logic [OPW-1:0]  ALU_opcode;
  logic            busy, halted, illegal;

  modport master (
    input  start, IR,
    output PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin,
           Read, MDRin, MDRout, IRin, Yin, LOin, HIin,
           Rin, Rout, ALU_opcode, busy, halted, illegal
  );

  modport slave (
    output start, IR,
    input  PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin,
           Read, MDRin, MDRout, IRin, Yin, LOin, HIin,
           Rin, Rout, ALU_opcode, busy, halted, illegal
  );
endinterface

// File: rtl/alu_op_sequencer_reg_sel_decode.sv
// 4-to-16 one-hot register select decoder; output is all zeros when en=0.
module reg_sel_decode (
  input  logic        en,
  input  logic [3:0]  sel,
  output logic [15:0] onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// Hardwired fetch/execute sequencer driving the CPU datapath enables.
// Optional SEQ_SINGLE_STEP_EN adds a step input gating each new fetch.
module alu_op_sequencer
  import seq_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int OPW      = 5
) (
  input  logic clk,
  input  logic clr,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic step,
`endif
  alu_op_sequencer_if.master bus
);

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  ctl_t           ctl_q, ctl_d;
  logic [15:0]    rin_q, rin_d, rout_q, rout_d;
  logic [OPW-1:0] alu_q, alu_d;
  logic           busy_q, busy_d, halted_q, halted_d, illegal_q, illegal_d;
  logic           rin_en, rout_en;
  logic [3:0]     rout_sel;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  assign op = bus.IR[31:27];
  assign ra = bus.IR[26:23];
  assign rb = bus.IR[22:19];
  assign rc = bus.IR[18:15];

  state_t loop_st;
`ifdef SEQ_SINGLE_STEP_EN
  assign loop_st = STEP_WAIT;
`else
  assign loop_st = T0;
`endif

  // Next-state logic; the class decode is taken on the edge leaving T2.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    case (state_q)
      IDLE:   if (bus.start) state_d = T0;
      T0: begin
        state_d = T1;
        cnt_d   = 4'(MEM_WAIT - 1);
      end
      T1: begin
        if (cnt_q == 4'd0) state_d = T2;
        else               cnt_d   = cnt_q - 4'd1;
      end
      T2: begin
        if (!is_legal(op)) begin
          state_d   = IDLE;
          illegal_d = 1'b1;
        end else if (op == OP_NOP)  state_d = T0;
        else if (op == OP_HALT)     state_d = HALTED;
        else if (is_unary(op))      state_d = T4;
        else                        state_d = T3;
      end
      T3:     state_d = T4;
      T4:     state_d = T5;
      T5:     state_d = is_muldiv(op) ? T6 : loop_st;
      T6:     state_d = loop_st;
      HALTED: state_d = HALTED;
`ifdef SEQ_SINGLE_STEP_EN
      STEP_WAIT: if (step) state_d = T0;
`endif
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d   = IDLE;
      cnt_d     = '0;
      illegal_d = 1'b0;
    end
  end

  // Moore outputs decoded from the next state so they are flop-driven.
  always_comb begin
    ctl_d    = '0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_sel = rb;
    alu_d    = '0;
    case (state_d)
      T0: begin
        ctl_d.pc_out = 1'b1; ctl_d.mar_in = 1'b1;
        ctl_d.inc_pc = 1'b1; ctl_d.z_in   = 1'b1;
      end
      T1: begin
        ctl_d.zlo_out = 1'b1; ctl_d.pc_in  = 1'b1;
        ctl_d.read    = 1'b1; ctl_d.mdr_in = 1'b1;
      end
      T2: begin
        ctl_d.mdr_out = 1'b1; ctl_d.ir_in = 1'b1;
      end
      T3: begin
        rout_en = 1'b1; ctl_d.y_in = 1'b1;
      end
      T4: begin
        rout_en    = 1'b1;
        rout_sel   = is_unary(op) ? rb : rc;
        alu_d      = OPW'(op);
        ctl_d.z_in = 1'b1;
      end
      T5: begin
        ctl_d.zlo_out = 1'b1;
        if (is_muldiv(op)) ctl_d.lo_in = 1'b1;
        else               rin_en      = 1'b1;
      end
      T6: begin
        ctl_d.zhi_out = 1'b1; ctl_d.hi_in = 1'b1;
      end
      default: ;
    endcase
    busy_d   = !(state_d inside {IDLE, HALTED});
    halted_d = (state_d == HALTED);
  end

  reg_sel_decode u_rin_dec (.en(rin_en),  .sel(ra),       .onehot(rin_d));
  reg_sel_decode u_rout_dec(.en(rout_en), .sel(rout_sel), .onehot(rout_d));

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ctl_q     <= '0;
      rin_q     <= '0;
      rout_q    <= '0;
      alu_q     <= '0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctl_q     <= ctl_d;
      rin_q     <= rin_d;
      rout_q    <= rout_d;
      alu_q     <= alu_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.PCout      = ctl_q.pc_out;
  assign bus.MARin      = ctl_q.mar_in;
  assign bus.IncPC      = ctl_q.inc_pc;
  assign bus.Zin        = ctl_q.z_in;
  assign bus.ZLOout     = ctl_q.zlo_out;
  assign bus.ZHIout     = ctl_q.zhi_out;
  assign bus.PCin       = ctl_q.pc_in;
  assign bus.Read       = ctl_q.read;
  assign bus.MDRin      = ctl_q.mdr_in;
  assign bus.MDRout     = ctl_q.mdr_out;
  assign bus.IRin       = ctl_q.ir_in;
  assign bus.Yin        = ctl_q.y_in;
  assign bus.LOin       = ctl_q.lo_in;
  assign bus.HIin       = ctl_q.hi_in;
  assign bus.Rin        = rin_q;
  assign bus.Rout       = rout_q;
  assign bus.ALU_opcode = alu_q;
  assign bus.busy       = busy_q;
  assign bus.halted     = halted_q;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench: two sequencers (MEM_WAIT=1 and 3) checked cycle by cycle.
module tb_alu_op_sequencer;

  typedef struct packed {
    logic [13:0] en;     // PCout..HIin, PCout in the MSB
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu;
    logic        busy, halted, illegal;
  } snap_t;

  typedef struct {
    string       nm;
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    bit          unary, muldiv;
    logic [15:0] t3, t4, t5;
  } vec_t;

  localparam logic [13:0] EN_T0  = 14'h3C00;
  localparam logic [13:0] EN_T1  = 14'h02E0;
  localparam logic [13:0] EN_T2  = 14'h0018;
  localparam logic [13:0] EN_T3  = 14'h0004;
  localparam logic [13:0] EN_T4  = 14'h0400;
  localparam logic [13:0] EN_T5  = 14'h0200;
  localparam logic [13:0] EN_T5M = 14'h0202;
  localparam logic [13:0] EN_T6  = 14'h0101;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.OPW(5)) ifa();
  alu_op_sequencer_if #(.OPW(5)) ifb();

`ifdef SEQ_SINGLE_STEP_EN
  logic step = 1'b1;
`endif

  alu_op_sequencer #(.MEM_WAIT(1), .OPW(5)) dut_a (
    .clk(clk), .clr(clr),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .bus(ifa.master));

  alu_op_sequencer #(.MEM_WAIT(3), .OPW(5)) dut_b (
    .clk(clk), .clr(clr),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .bus(ifb.master));

  snap_t snap_a, snap_b;
  assign snap_a = {ifa.PCout, ifa.MARin, ifa.IncPC, ifa.Zin, ifa.ZLOout, ifa.ZHIout,
                   ifa.PCin, ifa.Read, ifa.MDRin, ifa.MDRout, ifa.IRin, ifa.Yin,
                   ifa.LOin, ifa.HIin, ifa.Rin, ifa.Rout, ifa.ALU_opcode,
                   ifa.busy, ifa.halted, ifa.illegal};
  assign snap_b = {ifb.PCout, ifb.MARin, ifb.IncPC, ifb.Zin, ifb.ZLOout, ifb.ZHIout,
                   ifb.PCin, ifb.Read, ifb.MDRin, ifb.MDRout, ifb.IRin, ifb.Yin,
                   ifb.LOin, ifb.HIin, ifb.Rin, ifb.Rout, ifb.ALU_opcode,
                   ifb.busy, ifb.halted, ifb.illegal};

  snap_t exp_q[$];
  string nm_q[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic snap_t mk(input logic [13:0] en, input logic [15:0] rin,
                               input logic [15:0] rout, input logic [4:0] alu,
                               input logic busy, input logic halted, input logic ill);
    return {en, rin, rout, alu, busy, halted, ill};
  endfunction

  task automatic push(input string nm, input snap_t s);
    exp_q.push_back(s);
    nm_q.push_back(nm);
  endtask

  task automatic push_fetch(input string nm, input int mw);
    push({nm, "_T0"}, mk(EN_T0, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < mw; i++) push({nm, "_T1"}, mk(EN_T1, 0, 0, 0, 1, 0, 0));
    push({nm, "_T2"}, mk(EN_T2, 0, 0, 0, 1, 0, 0));
  endtask

  task automatic chk(input int sel);
    snap_t act, exp;
    string nm;
    @(negedge clk);
    act = (sel == 0) ? snap_a : snap_b;
    exp = exp_q.pop_front();
    nm  = nm_q.pop_front();
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drain(input int sel);
    while (exp_q.size() > 0) chk(sel);
  endtask

  task automatic start_dut(input int sel, input logic [31:0] ir);
    if (sel == 0) ifa.IR = ir; else ifb.IR = ir;
    @(posedge clk); #1;
    if (sel == 0) ifa.start = 1'b1; else ifb.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask

  // Called just after a negedge: clear, then the state must be IDLE.
  task automatic clr_check(input int sel, input string nm);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    push(nm, mk(0, 0, 0, 0, 0, 0, 0));
    chk(sel);
  endtask

  task automatic run_vec(input int sel, input int mw, input vec_t v);
    start_dut(sel, {v.op, v.ra, v.rb, v.rc, 15'b0});
    push_fetch(v.nm, mw);
    if (!v.unary) push({v.nm, "_T3"}, mk(EN_T3, 0, v.t3, 0, 1, 0, 0));
    push({v.nm, "_T4"}, mk(EN_T4, 0, v.t4, v.op, 1, 0, 0));
    push({v.nm, "_T5"}, mk(v.muldiv ? EN_T5M : EN_T5, v.t5, 0, 0, 1, 0, 0));
    if (v.muldiv) push({v.nm, "_T6"}, mk(EN_T6, 0, 0, 0, 1, 0, 0));
    push({v.nm, "_loopT0"}, mk(EN_T0, 0, 0, 0, 1, 0, 0));
    drain(sel);
    clr_check(sel, {v.nm, "_clr"});
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"add",  5'b00011, 4'd4,  4'd1,  4'd3, 1'b0, 1'b0, 16'h0002, 16'h0008, 16'h0010};
    vecs[1] = '{"not",  5'b10010, 4'd1,  4'd2,  4'd7, 1'b1, 1'b0, 16'h0000, 16'h0004, 16'h0002};
    vecs[2] = '{"mul",  5'b01111, 4'd5,  4'd6,  4'd7, 1'b0, 1'b1, 16'h0040, 16'h0080, 16'h0000};
    vecs[3] = '{"sub",  5'b00100, 4'd0,  4'd15, 4'd9, 1'b0, 1'b0, 16'h8000, 16'h0200, 16'h0001};
    vecs[4] = '{"neg",  5'b10001, 4'd15, 4'd0,  4'd3, 1'b1, 1'b0, 16'h0000, 16'h0001, 16'h8000};
    vecs[5] = '{"div",  5'b10000, 4'd2,  4'd3,  4'd4, 1'b0, 1'b1, 16'h0008, 16'h0010, 16'h0000};

    clr = 1'b1;
    ifa.start = 1'b0; ifa.IR = '0;
    ifb.start = 1'b0; ifb.IR = '0;
    repeat (2) @(posedge clk);
    push("reset_a", mk(0, 0, 0, 0, 0, 0, 0)); chk(0);
    push("reset_b", mk(0, 0, 0, 0, 0, 0, 0)); chk(1);
    @(posedge clk); #1;
    clr = 1'b0;

    // Table-driven instruction traces on the MEM_WAIT=1 sequencer.
    foreach (vecs[i]) run_vec(0, 1, vecs[i]);
    // The same ADD with a three-cycle memory read.
    run_vec(1, 3, vecs[0]);

    // clr asserted while in T4 of an ADD.
    start_dut(0, 32'h1A098000);
    push_fetch("midclr", 1);
    push("midclr_T3", mk(EN_T3, 0, 16'h0002, 0, 1, 0, 0));
    push("midclr_T4", mk(EN_T4, 0, 16'h0008, 5'b00011, 1, 0, 0));
    drain(0);
    clr_check(0, "midclr_idle");

    // NOP goes straight back to fetch.
    start_dut(0, {5'b11010, 27'b0});
    push_fetch("nop", 1);
    push("nop_T0", mk(EN_T0, 0, 0, 0, 1, 0, 0));
    push("nop_T1", mk(EN_T1, 0, 0, 0, 1, 0, 0));
    drain(0);
    clr_check(0, "nop_clr");

    // HALT holds through start toggles until clr.
    start_dut(0, {5'b11011, 27'b0});
    push_fetch("halt", 1);
    push("halt_state", mk(0, 0, 0, 0, 0, 1, 0));
    drain(0);
    for (int i = 0; i < 4; i++) begin
      ifa.start = (i % 2 == 0);
      push("halt_hold", mk(0, 0, 0, 0, 0, 1, 0));
      chk(0);
    end
    ifa.start = 1'b0;
    clr_check(0, "halt_clr");

    // Undefined opcode on the MEM_WAIT=3 sequencer: one-cycle pulse, then IDLE.
    start_dut(1, {5'b11111, 27'b0});
    push_fetch("illegal", 3);
    push("illegal_pulse", mk(0, 0, 0, 0, 0, 0, 1));
    push("illegal_idle1", mk(0, 0, 0, 0, 0, 0, 0));
    push("illegal_idle2", mk(0, 0, 0, 0, 0, 0, 0));
    drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
